// File: rtl/spi_txn_arbiter_pkg.sv
// Shared field widths, chip-select levels and FSM encodings for spi_txn_arbiter.
package spi_txn_arbiter_pkg;

  localparam int CMD_BITS_DEF       = 8;
  localparam int ADDR_BITS_DEF      = 8;
  localparam int PAYLOAD_BITS_DEF   = 8;
  localparam int MASTER_FRAME_WIDTH = CMD_BITS_DEF + ADDR_BITS_DEF + PAYLOAD_BITS_DEF;

  // The SPI master drives an active-low chip select.
  localparam logic CS_ASSERT   = 1'b0;
  localparam logic CS_DEASSERT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ARB        = 3'd1,
    ST_LAUNCH     = 3'd2,
    ST_WAIT_START = 3'd3,
    ST_WAIT_END   = 3'd4,
    ST_DONE       = 3'd5
  } arb_state_e;

endpackage

// File: rtl/spi_txn_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after rr_ptr, wrapping modulo NUM_REQ.
module spi_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       grant_valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    cand_idx    = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = int'(rr_ptr) + off;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = cand[IDX_W-1:0];
      if (!grant_valid && req[cand_idx]) begin
        grant_idx   = cand_idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one SPI master between NUM_REQ requesters: arbitrate, launch a frame, return the reply.
// Optional start timeout is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_txn_arbiter
  import spi_txn_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int CMD_BITS      = CMD_BITS_DEF,
  parameter int ADDR_BITS     = ADDR_BITS_DEF,
  parameter int PAYLOAD_BITS  = PAYLOAD_BITS_DEF,
  parameter int START_TIMEOUT = 64
) (
  input  logic                                      sysclk,
  input  logic                                      rst_n,
  input  logic [NUM_REQ-1:0]                        req,
  input  logic [NUM_REQ*CMD_BITS-1:0]               req_cmd,
  input  logic [NUM_REQ*ADDR_BITS-1:0]              req_addr,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0]           req_data,
  output logic [NUM_REQ-1:0]                        ack,
  output logic [PAYLOAD_BITS-1:0]                   rsp_data,
  output logic                                      rsp_err,
  output logic                                      busy,
  output logic                                      m_tx_enb,
  output logic [CMD_BITS+ADDR_BITS+PAYLOAD_BITS-1:0] m_frame,
  input  logic                                      m_cs,
  input  logic [PAYLOAD_BITS-1:0]                   m_rx
);

  localparam int               IDX_W    = $clog2(NUM_REQ);
  localparam int               FRAME_W  = CMD_BITS + ADDR_BITS + PAYLOAD_BITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || START_TIMEOUT < 1) begin : g_bad_params
    $error("spi_txn_arbiter: NUM_REQ must be 2..8 and START_TIMEOUT at least 1");
  end

  arb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic [FRAME_W-1:0]      frame_q, frame_d;
  logic [PAYLOAD_BITS-1:0] rsp_data_q, rsp_data_d;

  logic [IDX_W-1:0]        arb_idx;
  logic                    arb_valid;
  logic                    start_timeout;

  logic [CMD_BITS-1:0]     sel_cmd;
  logic [ADDR_BITS-1:0]    sel_addr;
  logic [PAYLOAD_BITS-1:0] sel_data;

  spi_rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .req        (req),
    .rr_ptr     (rr_ptr_q),
    .grant_idx  (arb_idx),
    .grant_valid(arb_valid)
  );

  always_comb begin
    sel_cmd  = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        sel_cmd  = req_cmd[i*CMD_BITS +: CMD_BITS];
        sel_addr = req_addr[i*ADDR_BITS +: ADDR_BITS];
        sel_data = req_data[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int              TO_W    = $clog2(START_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(START_TIMEOUT - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            rsp_err_q, rsp_err_d;

  // Counter is cleared while launching and counts every cycle spent waiting for chip select.
  always_comb begin
    to_cnt_d  = to_cnt_q;
    rsp_err_d = rsp_err_q;
    if (state_q == ST_LAUNCH) begin
      to_cnt_d = '0;
    end else if (state_q == ST_WAIT_START && to_cnt_q != TO_LAST) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
    if (state_q == ST_WAIT_END && m_cs == CS_DEASSERT) begin
      rsp_err_d = 1'b0;
    end else if (start_timeout && m_cs != CS_ASSERT) begin
      rsp_err_d = 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      to_cnt_q  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign start_timeout = (state_q == ST_WAIT_START) && (to_cnt_q == TO_LAST);
  assign rsp_err       = rsp_err_q;
`else
  assign start_timeout = 1'b0;
  assign rsp_err       = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    frame_d    = frame_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_ARB;
        end
      end
      ST_ARB: begin
        // A request that vanished before arbitration simply returns us to idle.
        if (arb_valid) begin
          grant_d = arb_idx;
          frame_d = {sel_cmd, sel_addr, sel_data};
          state_d = ST_LAUNCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (m_cs == CS_ASSERT) begin
          state_d = ST_WAIT_END;
        end else if (start_timeout) begin
          rsp_data_d = '0;
          state_d    = ST_DONE;
        end
      end
      ST_WAIT_END: begin
        if (m_cs == CS_DEASSERT) begin
          rsp_data_d = m_rx;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      frame_q    <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      frame_q    <= frame_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign m_tx_enb = (state_q == ST_LAUNCH);
  assign m_frame  = frame_q;
  assign rsp_data = rsp_data_q;
  assign ack      = (state_q == ST_DONE) ? (NUM_REQ'(1) << grant_q) : '0;

endmodule
